// File: rtl/full_sub_pkg.sv
// Shared constants and result type for the full subtractor.
package full_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 1;
   localparam int unsigned MAX_WIDTH     = 64;

   // Result payload; diff sized for the widest legal operand, zero-extended.
   typedef struct packed {
      logic                 bout;
      logic [MAX_WIDTH-1:0] diff;
   } sub_result_t;

endpackage : full_sub_pkg

// File: rtl/fs_bit_cell.sv
// One-bit combinational full subtractor cell.
module fs_bit_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign diff  = w_axb ^ bin;
   // Borrow when a is 0 and b is 1, or when a equals b and a borrow comes in.
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule : fs_bit_cell

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor with a single registered output stage.
module full_subtractor
   import full_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             out_valid
);

   logic [WIDTH-1:0] w_diff;
   logic [WIDTH:0]   w_borrow;

   logic [WIDTH-1:0] r_diff;
   logic             r_bout;
   logic             r_out_valid;

   assign w_borrow[0] = bin;

   // Borrow ripples from bit 0 upward; the last cell's borrow is the block borrow-out.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fs_bit_cell u_cell (
         .a    (a[gi]),
         .b    (b[gi]),
         .bin  (w_borrow[gi]),
         .diff (w_diff[gi]),
         .bout (w_borrow[gi+1])
      );
   end

   // Output stage: capture only on valid input so idle-cycle inputs never reach the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff      <= '0;
         r_bout      <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_diff <= w_diff;
            r_bout <= w_borrow[WIDTH];
         end
      end
   end

   assign diff      = r_diff;
   assign bout      = r_bout;
   assign out_valid = r_out_valid;

endmodule : full_subtractor

// File: tb/tb_full_subtractor.sv
// Scoreboard bench for full_subtractor at WIDTH=1 and WIDTH=8.
interface sub_inf #(
   parameter int unsigned WIDTH = 1
) (
   input logic clk
);
   logic             rst;
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             out_valid;
endinterface : sub_inf

module tb_full_subtractor;
   import full_sub_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   sub_inf #(.WIDTH(1)) if1 (.clk(clk));
   sub_inf #(.WIDTH(8)) if8 (.clk(clk));

   full_subtractor #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (if1.rst),
      .in_valid  (if1.in_valid),
      .a         (if1.a),
      .b         (if1.b),
      .bin       (if1.bin),
      .diff      (if1.diff),
      .bout      (if1.bout),
      .out_valid (if1.out_valid)
   );

   full_subtractor #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (if8.rst),
      .in_valid  (if8.in_valid),
      .a         (if8.a),
      .b         (if8.b),
      .bin       (if8.bin),
      .diff      (if8.diff),
      .bout      (if8.bout),
      .out_valid (if8.out_valid)
   );

   int checks = 0;
   int errors = 0;

   sub_result_t q1[$];
   sub_result_t q8[$];
   sub_result_t e1 = '0;
   sub_result_t e8 = '0;
   sub_result_t hold1 = '0;
   sub_result_t hold8 = '0;
   logic ov1_exp = 1'b0;
   logic ov8_exp = 1'b0;
   logic clr = 1'b1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference: difference from WIDTH+1-bit arithmetic, borrow from unsigned compare.
   function automatic sub_result_t model(input logic [63:0] ma, input logic [63:0] mb,
                                         input logic mbin, input int unsigned w);
      sub_result_t r;
      logic [64:0] full;
      logic [63:0] mask;
      mask   = (w >= 64) ? '1 : ((64'(1) << w) - 64'(1));
      full   = {1'b0, ma} - {1'b0, mb} - 65'(mbin);
      r.diff = full[63:0] & mask;
      r.bout = ({1'b0, ma} < ({1'b0, mb} + 65'(mbin)));
      return r;
   endfunction

   // Stimulus side of the scoreboard: record what each edge should produce.
   always @(posedge clk) begin
      clr     = if1.rst;
      ov1_exp = if1.in_valid && !if1.rst;
      ov8_exp = if8.in_valid && !if8.rst;
      if (ov1_exp) q1.push_back(e1);
      if (ov8_exp) q8.push_back(e8);
   end

   // Monitor for the 1-bit instance.
   always @(negedge clk) begin
      sub_result_t ex;
      if (clr) hold1 = '0;
      check("w1_out_valid", 64'(if1.out_valid), 64'(ov1_exp));
      if (if1.out_valid) begin
         if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL w1_unexpected_result actual=valid required=none t=%0t", $time);
         end else begin
            ex = q1.pop_front();
            check("w1_diff", 64'(if1.diff), ex.diff);
            check("w1_bout", 64'(if1.bout), 64'(ex.bout));
            hold1 = ex;
         end
      end else begin
         if (ov1_exp && q1.size() != 0) void'(q1.pop_front());
         check("w1_hold_diff", 64'(if1.diff), hold1.diff);
         check("w1_hold_bout", 64'(if1.bout), 64'(hold1.bout));
      end
   end

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      sub_result_t ex;
      if (clr) hold8 = '0;
      check("w8_out_valid", 64'(if8.out_valid), 64'(ov8_exp));
      if (if8.out_valid) begin
         if (q8.size() == 0) begin
            checks++; errors++;
            $display("FAIL w8_unexpected_result actual=valid required=none t=%0t", $time);
         end else begin
            ex = q8.pop_front();
            check("w8_diff", 64'(if8.diff), ex.diff);
            check("w8_bout", 64'(if8.bout), 64'(ex.bout));
            hold8 = ex;
         end
      end else begin
         if (ov8_exp && q8.size() != 0) void'(q8.pop_front());
         check("w8_hold_diff", 64'(if8.diff), hold8.diff);
         check("w8_hold_bout", 64'(if8.bout), 64'(hold8.bout));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic da, input logic db, input logic dbin,
                         input logic ed, input logic eb);
      if1.in_valid = v;
      if1.a        = da;
      if1.b        = db;
      if1.bin      = dbin;
      e1           = '{bout: eb, diff: 64'(ed)};
      step();
   endtask

   task automatic drive8(input logic v, input logic [7:0] da, input logic [7:0] db,
                         input logic dbin, input logic [7:0] ed, input logic eb);
      if8.in_valid = v;
      if8.a        = da;
      if8.b        = db;
      if8.bin      = dbin;
      e8           = '{bout: eb, diff: 64'(ed)};
      step();
   endtask

   task automatic set_rst(input logic r);
      if1.rst = r;
      if8.rst = r;
   endtask

   // Rows: {a, b, bin, diff, bout} for the 1-bit truth table.
   logic [4:0] tbl1 [8];
   // Rows: {a, b, bin, diff, bout} for 8-bit directed cases.
   logic [25:0] tbl8 [11];

   initial begin
      tbl1[0] = 5'b000_0_0; tbl1[1] = 5'b001_1_1;
      tbl1[2] = 5'b010_1_1; tbl1[3] = 5'b011_0_1;
      tbl1[4] = 5'b100_1_0; tbl1[5] = 5'b101_0_0;
      tbl1[6] = 5'b110_0_0; tbl1[7] = 5'b111_1_1;

      tbl8[0]  = {8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      tbl8[1]  = {8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
      tbl8[2]  = {8'h55, 8'h55, 1'b0, 8'h00, 1'b0};
      tbl8[3]  = {8'h55, 8'h55, 1'b1, 8'hFF, 1'b1};
      tbl8[4]  = {8'h10, 8'h03, 1'b1, 8'h0C, 1'b0};
      tbl8[5]  = {8'h03, 8'h10, 1'b0, 8'hF3, 1'b1};
      tbl8[6]  = {8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      tbl8[7]  = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      tbl8[8]  = {8'hA0, 8'h50, 1'b0, 8'h50, 1'b0};
      tbl8[9]  = {8'h50, 8'hA0, 1'b0, 8'hB0, 1'b1};
      tbl8[10] = {8'h7F, 8'h80, 1'b1, 8'hFE, 1'b1};

      set_rst(1'b1);
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.bin = 1'b0;
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
      step();
      step();
      set_rst(1'b0);

      // 1-bit truth table, back to back.
      for (int i = 0; i < 8; i++) begin
         logic [4:0] r;
         r = tbl1[i];
         drive1(1'b1, r[4], r[3], r[2], r[1], r[0]);
      end
      drive1(1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0);

      // Reset held two cycles while valid input is presented.
      set_rst(1'b1);
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      set_rst(1'b0);
      drive1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      drive1(1'b0, 1'bx, 1'bx, 1'bx, 1'b0, 1'b0);

      // Valid toggling 1,0,1 with X operands in the gap.
      drive8(1'b1, 8'h10, 8'h03, 1'b1, 8'h0C, 1'b0);
      drive8(1'b0, 8'hxx, 8'hxx, 1'bx, 8'h00, 1'b0);
      drive8(1'b1, 8'h03, 8'h10, 1'b0, 8'hF3, 1'b1);
      drive8(1'b0, 8'hxx, 8'hxx, 1'bx, 8'h00, 1'b0);

      // 8-bit directed cases, back to back.
      for (int i = 0; i < 11; i++) begin
         logic [25:0] r;
         r = tbl8[i];
         drive8(1'b1, r[25:18], r[17:10], r[9], r[8:1], r[0]);
      end
      drive8(1'b0, 8'hxx, 8'hxx, 1'bx, 8'h00, 1'b0);
      step();

      // Random back-to-back traffic on both widths at once.
      for (int i = 0; i < 10; i++) begin
         logic [7:0] ra8, rb8;
         logic       ra1, rb1, rc1, rc8;
         ra8 = 8'($urandom); rb8 = 8'($urandom); rc8 = 1'($urandom);
         ra1 = 1'($urandom); rb1 = 1'($urandom); rc1 = 1'($urandom);
         if1.in_valid = 1'b1; if1.a = ra1; if1.b = rb1; if1.bin = rc1;
         if8.in_valid = 1'b1; if8.a = ra8; if8.b = rb8; if8.bin = rc8;
         e1 = model(64'(ra1), 64'(rb1), rc1, 1);
         e8 = model(64'(ra8), 64'(rb8), rc8, 8);
         step();
      end
      if1.in_valid = 1'b0;
      if8.in_valid = 1'b0;
      step();
      step();
      step();

      check("q1_drained", 64'(q1.size()), 64'd0);
      check("q8_drained", 64'(q8.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "timeout");
   end

endmodule : tb_full_subtractor
